m6809_alu_exec: RTL and testbench
=================================

# m6809_alu_exec

Execute sequencer for 8-bit 6809 accumulator instructions, and the driving end of the combinational 8-bit ALU interface.
- Accepts one opcode plus one 8-bit operand per valid/ready handshake.
- Drives the ALU operand, op and flag-in inputs, and owns accumulators A and B and the condition-code register CC.
- Returns each result on a valid/ready response channel.
- Sits between operand fetch (upstream) and memory write-back (downstream).

## Interface
- CC_RESET, 8'h50, CC value loaded on reset (F and I set).
- clk  input  1  core clock, all state on rising edge.
- reset  input  1  asynchronous, active-high.
- cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
- cmd_opcode  input  8  6809 page-0 opcode.
- cmd_operand  input  8  immediate or memory-read byte.
- rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
- rsp_data  output  8  result byte.
- rsp_mem_wr  output  1  rsp_data must be written to memory.
- rsp_err  output  1  opcode is illegal or unsupported.
- acc_a, acc_b, cc  output  8 each  architectural registers.
- cc_wr_en / cc_wr_data  input  1 / 8  external CC load (ANDCC, ORCC, PULS).
- alu_in_a, alu_in_b  output  8 each  ALU operands.
- alu_op  output  4  ALU opcode, equal to cmd_opcode[3:0].
- alu_op7  output  1  ALU disambiguation bit, equal to cmd_opcode[7].
- alu_c_in, alu_v_in, alu_h_in  output  1 each  driven from CC.C, CC.V and CC.H.
- alu_out  input  8  ALU result.
- alu_c, alu_z, alu_n, alu_v, alu_h  input  1 each  ALU flags.

## Operation
**CC layout:** E7 F6 H5 I4 N3 Z2 V1 C0.

**Command classes,** by cmd_opcode[7:4]:
- 4x: unary on A. alu_in_a=A, alu_in_b=0. Result to A.
- 5x: unary on B. alu_in_a=B, alu_in_b=0. Result to B.
- 0x, 6x, 7x: unary on memory. alu_in_a=operand, alu_in_b=0. Result to rsp_data with rsp_mem_wr=1.
- 8x–Bx: binary on A (acc=A). Cx–Fx: binary on B (acc=B). For both:
  - alu_in_a=acc, alu_in_b=operand.
  - Low nibble 6 (LD) is the exception: alu_in_a=operand.

**Destinations within the binary classes:**
- Low nibble 1 (CMP) and 5 (BIT): flags only, accumulator unchanged, rsp_mem_wr=0.
- Low nibble 7 (ST): rsp_data=acc, rsp_mem_wr=1, accumulator unchanged.
- All other legal low nibbles: result to acc.

**Illegal opcodes:**
- Upper nibble 1, 2 or 3.
- Unary low nibble 1, 2, 5, B or E.
- Binary low nibble 3, C, D, E or F.
- Response: rsp_err=1, rsp_data=0, rsp_mem_wr=0. A, B and CC are unchanged.

**CC update for legal commands:**
- N, Z, V, C come from the ALU; H comes from alu_h. E, F and I are preserved.
- Overrides:
  - COM: C:=1.
  - INC and DEC: C := old C.
  - ST and LD: V:=0, C := old C.

**State machine:** IDLE → EXEC → RESP → IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch opcode and operand, then go to EXEC.
- EXEC:
  - cmd_ready=0.
  - ALU inputs are driven from the latched values.
  - At the clock edge, register rsp_data/rsp_mem_wr/rsp_err, update the destination register and CC, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_* and registers are stable.
  - On rsp_ready, go to IDLE.
- Outside EXEC the ALU outputs hold the last latched values.

**External CC load:**
- cc_wr_en in any cycle except the EXEC edge: CC:=cc_wr_data.
- At the EXEC edge the command's CC update wins and cc_wr_en is dropped.

## Timing
- **Reset values:**
  - State IDLE; cmd_ready=1 after reset deasserts (0 while reset is asserted).
  - rsp_valid=0, rsp_data=0, rsp_mem_wr=0, rsp_err=0.
  - A=0, B=0, CC=CC_RESET.
  - ALU input outputs=0.
- **Latency:**
  - Handshake in cycle N, EXEC in N+1, rsp_valid=1 in N+2.
  - acc_a, acc_b and cc show new values from N+2.
  - Peak rate is one command per 3 cycles with rsp_ready tied high.
- **Backpressure:**
  - rsp_valid holds and all rsp_* are stable until rsp_ready=1.
  - cmd_ready stays 0 until the state returns to IDLE.
- **Reset mid-operation:** the in-flight command is discarded; no partial register update or response.
- rsp_ready asserted while rsp_valid=0 is ignored.

## Test plan
- Reset with CC_RESET default: A=0, B=0, CC=0x50, rsp_valid=0. After release, cmd_ready=1.
- ADDA #: A=0x7F, opcode 0x8B, operand 0x01 → A=0x80, N=1, V=1, Z=0, C=0. rsp_valid at N+2.
- CMPB / STA: B=0x10, CMPB 0xC1 operand 0x10 → B unchanged, Z=1, C=0, rsp_mem_wr=0. Then STA 0xB7 with A=0x55 → rsp_data=0x55, rsp_mem_wr=1, V=0.
- COM on memory: opcode 0x63, operand 0x0F → rsp_data=0xF0, rsp_mem_wr=1, C=1, N=1.
- Illegal opcode 0x8D with CC=0x5F → rsp_err=1, A, B and CC unchanged.
- Backpressure and reset: rsp_ready low for 5 cycles → rsp_* stable and cmd_ready=0. Separately, assert reset during EXEC → A, B and CC return to reset values and no response is issued.

Source files
------------

// File: rtl/m6809_alu_exec.sv
// Execute sequencer for 6809 page-0 accumulator/memory instructions: drives the external ALU,
// owns A, B and CC, and returns one response per command (IDLE -> EXEC -> RESP).
module m6809_alu_exec #(
  parameter logic [7:0] CC_RESET = 8'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_opcode,
  input  logic [7:0] cmd_operand,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_mem_wr,
  output logic       rsp_err,
  output logic [7:0] acc_a,
  output logic [7:0] acc_b,
  output logic [7:0] cc,
  input  logic       cc_wr_en,
  input  logic [7:0] cc_wr_data,
  output logic [7:0] alu_in_a,
  output logic [7:0] alu_in_b,
  output logic [3:0] alu_op,
  output logic       alu_op7,
  output logic       alu_c_in,
  output logic       alu_v_in,
  output logic       alu_h_in,
  input  logic [7:0] alu_out,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_v,
  input  logic       alu_h
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t     state;
  logic [7:0] op_q;

  assign cmd_ready = (state == S_IDLE) && !reset;
  assign alu_op    = op_q[3:0];
  assign alu_op7   = op_q[7];
  assign alu_c_in  = cc[0];
  assign alu_v_in  = cc[1];
  assign alu_h_in  = cc[5];

  // ALU operand selection for the command being accepted; A/B cannot change before EXEC.
  logic [3:0] c_hi, c_lo;
  logic [7:0] in_a_d, in_b_d;
  assign c_hi = cmd_opcode[7:4];
  assign c_lo = cmd_opcode[3:0];

  always_comb begin
    in_a_d = cmd_operand;
    in_b_d = 8'h00;
    if (c_hi == 4'h4) begin
      in_a_d = acc_a;
    end else if (c_hi == 4'h5) begin
      in_a_d = acc_b;
    end else if (cmd_opcode[7]) begin
      in_b_d = cmd_operand;
      if (c_lo != 4'h6) in_a_d = cmd_opcode[6] ? acc_b : acc_a;
    end
  end

  // Decode of the latched command, used at the EXEC edge.
  logic [3:0] hi, lo;
  logic       binary, illegal, is_st, is_ld, flags_only, is_com, is_incdec, mem_dest, sel_b;
  logic [7:0] acc_cur, cc_new;
  logic       v_new, c_new;
  assign hi = op_q[7:4];
  assign lo = op_q[3:0];

  always_comb begin
    binary     = op_q[7];
    illegal    = (!binary && (hi == 4'h1 || hi == 4'h2 || hi == 4'h3))
              || (!binary && (lo inside {4'h1, 4'h2, 4'h5, 4'hB, 4'hE}))
              || ( binary && (lo inside {4'h3, 4'hC, 4'hD, 4'hE, 4'hF}));
    is_st      = binary && (lo == 4'h7);
    is_ld      = binary && (lo == 4'h6);
    flags_only = binary && (lo == 4'h1 || lo == 4'h5);
    is_com     = !binary && (lo == 4'h3);
    is_incdec  = !binary && (lo == 4'hA || lo == 4'hC);
    mem_dest   = !binary && (hi != 4'h4) && (hi != 4'h5);
    sel_b      = binary ? op_q[6] : (hi == 4'h5);
    acc_cur    = sel_b ? acc_b : acc_a;
    v_new      = (is_st || is_ld) ? 1'b0 : alu_v;
    c_new      = alu_c;
    if (is_com) c_new = 1'b1;
    if (is_incdec || is_st || is_ld) c_new = cc[0];
    cc_new     = {cc[7:6], alu_h, cc[4], alu_n, alu_z, v_new, c_new};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= 8'h00;
      alu_in_a   <= 8'h00;
      alu_in_b   <= 8'h00;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_mem_wr <= 1'b0;
      rsp_err    <= 1'b0;
      acc_a      <= 8'h00;
      acc_b      <= 8'h00;
      cc         <= CC_RESET;
    end else begin
      case (state)
        S_IDLE: begin
          if (cc_wr_en) cc <= cc_wr_data;
          if (cmd_valid) begin
            op_q     <= cmd_opcode;
            alu_in_a <= in_a_d;
            alu_in_b <= in_b_d;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          // External CC loads are dropped on this edge; the command's update wins.
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          if (illegal) begin
            rsp_err    <= 1'b1;
            rsp_data   <= 8'h00;
            rsp_mem_wr <= 1'b0;
          end else begin
            rsp_err    <= 1'b0;
            rsp_data   <= is_st ? acc_cur : alu_out;
            rsp_mem_wr <= is_st || mem_dest;
            cc         <= cc_new;
            if (!flags_only && !is_st && !mem_dest) begin
              if (sel_b) acc_b <= alu_out;
              else       acc_a <= alu_out;
            end
          end
        end
        S_RESP: begin
          if (cc_wr_en) cc <= cc_wr_data;
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m6809_alu_exec.sv
// Randomised scoreboard bench for m6809_alu_exec with a behavioural 6809 ALU stand-in.
module tb_m6809_alu_exec;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_opcode, cmd_operand;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_mem_wr, rsp_err;
  logic [7:0] acc_a, acc_b, cc;
  logic       cc_wr_en;
  logic [7:0] cc_wr_data;
  logic [7:0] alu_in_a, alu_in_b;
  logic [3:0] alu_op;
  logic       alu_op7, alu_c_in, alu_v_in, alu_h_in;
  logic [7:0] alu_out;
  logic       alu_c, alu_z, alu_n, alu_v, alu_h;

  always #5 clk = ~clk;

  m6809_alu_exec #(.CC_RESET(8'h50)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_mem_wr(rsp_mem_wr), .rsp_err(rsp_err),
    .acc_a(acc_a), .acc_b(acc_b), .cc(cc), .cc_wr_en(cc_wr_en), .cc_wr_data(cc_wr_data),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_op(alu_op), .alu_op7(alu_op7),
    .alu_c_in(alu_c_in), .alu_v_in(alu_v_in), .alu_h_in(alu_h_in),
    .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .alu_h(alu_h)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU stand-in returns {result, c, v, h}. It leaves C/V overrides of COM, INC/DEC, LD/ST
  // deliberately wrong so the sequencer's own overrides are observable.
  function automatic logic [10:0] alu_model(input logic op7, input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin, input logic vin,
                                            input logic hin);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, v, h;
    r = a; c = cin; v = vin; h = hin;
    if (op7) begin
      case (op)
        4'h0, 4'h1, 4'h2: begin
          w = {1'b0, a} - {1'b0, b} - ((op == 4'h2) ? {8'h00, cin} : 9'h000);
          r = w[7:0]; c = w[8]; v = (a[7] ^ b[7]) & (a[7] ^ r[7]);
        end
        4'h4, 4'h5: begin r = a & b; v = 1'b0; end
        4'h6, 4'h7: begin r = a; v = 1'b1; c = ~cin; end
        4'h8: begin r = a ^ b; v = 1'b0; end
        4'hA: begin r = a | b; v = 1'b0; end
        4'h9, 4'hB: begin
          w = {1'b0, a} + {1'b0, b} + ((op == 4'h9) ? {8'h00, cin} : 9'h000);
          r = w[7:0]; c = w[8]; v = ~(a[7] ^ b[7]) & (a[7] ^ r[7]); h = a[4] ^ b[4] ^ r[4];
        end
        default: ;
      endcase
    end else begin
      case (op)
        4'h0: begin r = 8'h00 - a; c = (a != 8'h00); v = (a == 8'h80); end
        4'h3: begin r = ~a; v = 1'b0; c = 1'b0; end
        4'h4: begin r = {1'b0, a[7:1]}; c = a[0]; end
        4'h6: begin r = {cin, a[7:1]}; c = a[0]; end
        4'h7: begin r = {a[7], a[7:1]}; c = a[0]; end
        4'h8: begin r = {a[6:0], 1'b0}; c = a[7]; v = a[7] ^ a[6]; end
        4'h9: begin r = {a[6:0], cin}; c = a[7]; v = a[7] ^ a[6]; end
        4'hA: begin r = a - 8'h01; v = (a == 8'h80); c = ~cin; end
        4'hC: begin r = a + 8'h01; v = (a == 8'h7F); c = ~cin; end
        4'hD: begin v = 1'b0; end
        4'hF: begin r = 8'h00; v = 1'b0; c = 1'b0; end
        default: ;
      endcase
    end
    return {r, c, v, h};
  endfunction

  logic [10:0] alu_res;
  assign alu_res = alu_model(alu_op7, alu_op, alu_in_a, alu_in_b, alu_c_in, alu_v_in, alu_h_in);
  assign alu_out = alu_res[10:3];
  assign alu_c   = alu_res[2];
  assign alu_v   = alu_res[1];
  assign alu_h   = alu_res[0];
  assign alu_z   = (alu_res[10:3] == 8'h00);
  assign alu_n   = alu_res[10];

  typedef struct {
    logic [7:0] data;
    logic       mem_wr;
    logic       err;
    logic [7:0] a, b, cc;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m_a, m_b, m_cc;
  logic [7:0] last_data;
  logic       last_mem_wr, last_err;
  int         force_hold = -1;

  // Architectural reference: what a 6809 does to A, B, CC and memory for this instruction.
  task automatic predict(input logic [7:0] op, input logic [7:0] opnd, output exp_t e);
    logic [3:0]  hi, lo;
    logic        bin, illegal, on_a, on_b;
    logic [7:0]  src, x, y, res;
    logic [10:0] r;
    logic        n, z, v, c, h;
    hi = op[7:4]; lo = op[3:0];
    bin = (hi >= 4'h8);
    illegal = (hi >= 4'h1 && hi <= 4'h3) || (!bin && (lo inside {4'h1, 4'h2, 4'h5, 4'hB, 4'hE}))
           || (bin && (lo inside {4'h3, 4'hC, 4'hD, 4'hE, 4'hF}));
    on_a = (hi == 4'h4) || (bin && hi < 4'hC);
    on_b = (hi == 4'h5) || (hi >= 4'hC);
    e.err = illegal; e.data = 8'h00; e.mem_wr = 1'b0;
    if (!illegal) begin
      src = on_a ? m_a : (on_b ? m_b : opnd);
      x = (bin && lo == 4'h6) ? opnd : src;
      y = bin ? opnd : 8'h00;
      r = alu_model(bin, lo, x, y, m_cc[0], m_cc[1], m_cc[5]);
      res = r[10:3]; c = r[2]; v = r[1]; h = r[0]; n = res[7]; z = (res == 8'h00);
      if (!bin && lo == 4'h3) c = 1'b1;
      if (!bin && (lo == 4'hA || lo == 4'hC)) c = m_cc[0];
      if (bin && (lo == 4'h6 || lo == 4'h7)) begin v = 1'b0; c = m_cc[0]; end
      e.data = (bin && lo == 4'h7) ? src : res;
      e.mem_wr = (bin && lo == 4'h7) || (!on_a && !on_b);
      if (!(bin && (lo inside {4'h1, 4'h5, 4'h7}))) begin
        if (on_a) m_a = res;
        else if (on_b) m_b = res;
      end
      m_cc = {m_cc[7:6], h, m_cc[4], n, z, v, c};
    end
    e.a = m_a; e.b = m_b; e.cc = m_cc; e.cyc = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready) chk("idle timeout", 0, 1);
  endtask

  task automatic cc_write(input logic [7:0] d);
    wait_idle();
    cc_wr_en = 1'b1; cc_wr_data = d; m_cc = d;
    @(negedge clk);
    cc_wr_en = 1'b0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [7:0] opnd, input bit exec_ccw, input bit rst_exec);
    int   t = 0;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_operand = opnd;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      chk("cmd_ready timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    if (!rst_exec) begin
      predict(op, opnd, e);
      e.cyc = cyc + 2;
      q.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_ready low in EXEC", cmd_ready, 0);
    if (exec_ccw) begin cc_wr_en = 1'b1; cc_wr_data = 8'($urandom); end
    if (rst_exec) reset = 1'b1;
    @(negedge clk);
    cc_wr_en = 1'b0;
  endtask

  initial begin : monitor
    exp_t       e;
    int         hold;
    bit         stable;
    logic [7:0] sd;
    logic       sm, se;
    forever begin
      @(negedge clk);
      if (rsp_valid && !reset) begin
        if (q.size() == 0) begin
          chk("unexpected response", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rsp latency", cyc, e.cyc);
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_mem_wr", rsp_mem_wr, e.mem_wr);
          chk("rsp_err", rsp_err, e.err);
          chk("acc_a", acc_a, e.a);
          chk("acc_b", acc_b, e.b);
          chk("cc", cc, e.cc);
        end
        last_data = rsp_data; last_mem_wr = rsp_mem_wr; last_err = rsp_err;
        sd = rsp_data; sm = rsp_mem_wr; se = rsp_err;
        if (force_hold >= 0) begin hold = force_hold; force_hold = -1; end
        else hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        rsp_ready = 1'b0;
        stable = 1'b1;
        repeat (hold) begin
          @(negedge clk);
          if (!rsp_valid || cmd_ready || rsp_data !== sd || rsp_mem_wr !== sm || rsp_err !== se) stable = 1'b0;
        end
        if (hold > 0) chk("rsp stable under backpressure", stable, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_valid drops after accept", rsp_valid, 0);
        rsp_ready = 1'b0;
      end else begin
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    bit quiet;
    reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = 8'h00; cmd_operand = 8'h00;
    cc_wr_en = 1'b0; cc_wr_data = 8'h00; rsp_ready = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_cc = 8'h50;
    repeat (3) @(negedge clk);
    chk("reset cmd_ready", cmd_ready, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset acc_a", acc_a, 8'h00);
    chk("reset acc_b", acc_b, 8'h00);
    chk("reset cc", cc, 8'h50);
    chk("reset alu inputs", {alu_in_a, alu_in_b, alu_op, alu_op7, alu_c_in, alu_v_in, alu_h_in}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("cmd_ready after reset", cmd_ready, 1);

    issue(8'h86, 8'h7F, 0, 0);
    issue(8'h8B, 8'h01, 0, 0);
    wait_idle();
    chk("ADDA overflow A", acc_a, 8'h80);
    chk("ADDA NZVC", cc[3:0], 4'b1010);

    issue(8'hC6, 8'h10, 0, 0);
    issue(8'hC1, 8'h10, 0, 0);
    wait_idle();
    chk("CMPB keeps B", acc_b, 8'h10);
    chk("CMPB Z", cc[2], 1);
    chk("CMPB C", cc[0], 0);
    chk("CMPB no mem write", last_mem_wr, 0);

    issue(8'h86, 8'h55, 0, 0);
    issue(8'hB7, 8'hAA, 0, 0);
    wait_idle();
    chk("STA data", last_data, 8'h55);
    chk("STA mem write", last_mem_wr, 1);
    chk("STA V", cc[1], 0);

    issue(8'h63, 8'h0F, 0, 0);
    wait_idle();
    chk("COM data", last_data, 8'hF0);
    chk("COM mem write", last_mem_wr, 1);
    chk("COM C", cc[0], 1);
    chk("COM N", cc[3], 1);

    cc_write(8'h5F);
    issue(8'h8D, 8'h12, 0, 0);
    wait_idle();
    chk("illegal err", last_err, 1);
    chk("illegal data", last_data, 8'h00);
    chk("illegal keeps cc", cc, 8'h5F);
    chk("illegal keeps A", acc_a, 8'h55);
    chk("illegal keeps B", acc_b, 8'h10);

    force_hold = 5;
    issue(8'h4C, 8'h00, 0, 0);
    wait_idle();
    issue(8'h4F, 8'h00, 1, 0);
    wait_idle();

    issue(8'h8B, 8'h33, 0, 1);
    chk("mid-op reset A", acc_a, 8'h00);
    chk("mid-op reset B", acc_b, 8'h00);
    chk("mid-op reset cc", cc, 8'h50);
    chk("mid-op reset rsp_valid", rsp_valid, 0);
    chk("mid-op reset cmd_ready", cmd_ready, 0);
    reset = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_cc = 8'h50;
    quiet = 1'b1;
    repeat (4) begin @(negedge clk); if (rsp_valid) quiet = 1'b0; end
    chk("no response after reset", quiet, 1);
    chk("cmd_ready after mid-op reset", cmd_ready, 1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) cc_write(8'($urandom));
      issue(8'($urandom), 8'($urandom), $urandom_range(0, 3) == 0, 0);
    end
    wait_idle();
    chk("scoreboard drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
